// File: rtl/scalar_operand_stage.sv
// Decode-to-execute operand register for the scalar pipe.
// Forwards from execute/writeback and inserts load-use bubbles.
module scalar_operand_stage #(
    parameter int registerSize  = 8,
    parameter int selectionBits = 3,
    parameter int opcodeSize    = 5,
    parameter int counterSize   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inValid,
    input  logic [opcodeSize-1:0]    inOpcode,
    input  logic [selectionBits-1:0] rSel1,
    input  logic [selectionBits-1:0] rSel2,
    input  logic                     use1,
    input  logic                     use2,
    input  logic [registerSize-1:0]  reg1In,
    input  logic [registerSize-1:0]  reg2In,
    input  logic [selectionBits-1:0] inRd,
    input  logic                     inRegWrEn,
    input  logic                     inIsLoad,
    input  logic [registerSize-1:0]  exResult,
    input  logic                     wbWrEn,
    input  logic [selectionBits-1:0] wbRd,
    input  logic [registerSize-1:0]  wbData,
    input  logic                     exStall,
    input  logic                     flush,
    output logic                     outValid,
    output logic [opcodeSize-1:0]    outOpcode,
    output logic [registerSize-1:0]  outOp1,
    output logic [registerSize-1:0]  outOp2,
    output logic [selectionBits-1:0] outRd,
    output logic                     outRegWrEn,
    output logic                     outIsLoad,
    output logic                     stallOut,
    output logic [counterSize-1:0]   bubbleCount
);

    logic                     valid_q, valid_d;
    logic [opcodeSize-1:0]    opc_q, opc_d;
    logic [registerSize-1:0]  op1_q, op1_d;
    logic [registerSize-1:0]  op2_q, op2_d;
    logic [selectionBits-1:0] rd_q, rd_d;
    logic                     wr_q, wr_d;
    logic                     ld_q, ld_d;
    logic [counterSize-1:0]   cnt_q, cnt_d;

    logic                     ex_fwd_ok;
    logic                     load_hit;
    logic                     load_use;
    logic [registerSize-1:0]  sel1;
    logic [registerSize-1:0]  sel2;

    // Only a valid, non-load, writing instruction has a usable EX result.
    assign ex_fwd_ok = valid_q & wr_q & ~ld_q;
    // Load in stage whose data is not ready until writeback.
    assign load_hit  = valid_q & ld_q & wr_q;
    assign load_use  = inValid & load_hit &
                       ((use1 & (rSel1 == rd_q)) |
                        (use2 & (rSel2 == rd_q)));
    assign stallOut  = exStall | (load_use & ~flush);

    // Source 1 operand: EX beats WB (younger), else register file.
    always_comb begin
        sel1 = reg1In;
        if (use1) begin
            if (ex_fwd_ok && rSel1 == rd_q)
                sel1 = exResult;
            else if (wbWrEn && rSel1 == wbRd)
                sel1 = wbData;
        end
    end

    // Source 2 operand: same priority as source 1.
    always_comb begin
        sel2 = reg2In;
        if (use2) begin
            if (ex_fwd_ok && rSel2 == rd_q)
                sel2 = exResult;
            else if (wbWrEn && rSel2 == wbRd)
                sel2 = wbData;
        end
    end

    // Next state: flush, then hold, then bubble, then capture.
    always_comb begin
        valid_d = valid_q;
        opc_d   = opc_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        ld_d    = ld_q;
        cnt_d   = cnt_q;
        if (flush || (!exStall && load_use)) begin
            valid_d = 1'b0;
            opc_d   = '0;
            op1_d   = '0;
            op2_d   = '0;
            rd_d    = '0;
            wr_d    = 1'b0;
            ld_d    = 1'b0;
            if (!flush && cnt_q != '1)
                cnt_d = cnt_q + counterSize'(1);
        end else if (!exStall) begin
            valid_d = inValid;
            opc_d   = inOpcode;
            op1_d   = sel1;
            op2_d   = sel2;
            rd_d    = inRd;
            wr_d    = inRegWrEn;
            ld_d    = inIsLoad;
        end
    end

    // Stage registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            opc_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            rd_q    <= '0;
            wr_q    <= 1'b0;
            ld_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            opc_q   <= opc_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ld_q    <= ld_d;
            cnt_q   <= cnt_d;
        end
    end

    assign outValid    = valid_q;
    assign outOpcode   = opc_q;
    assign outOp1      = op1_q;
    assign outOp2      = op2_q;
    assign outRd       = rd_q;
    assign outRegWrEn  = wr_q;
    assign outIsLoad   = ld_q;
    assign bubbleCount = cnt_q;

endmodule

// File: tb/tb_scalar_operand_stage.sv
// Directed bench for scalar_operand_stage.
// Second instance with a 3-bit counter exercises saturation.
module tb_scalar_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        inValid;
    logic [4:0]  inOpcode;
    logic [2:0]  rSel1, rSel2;
    logic        use1, use2;
    logic [7:0]  reg1In, reg2In;
    logic [2:0]  inRd;
    logic        inRegWrEn, inIsLoad;
    logic [7:0]  exResult;
    logic        wbWrEn;
    logic [2:0]  wbRd;
    logic [7:0]  wbData;
    logic        exStall, flush;

    logic        outValid, outRegWrEn, outIsLoad, stallOut;
    logic [4:0]  outOpcode;
    logic [7:0]  outOp1, outOp2;
    logic [2:0]  outRd;
    logic [15:0] bubbleCount;

    logic        s_valid, s_wr, s_ld, s_stall;
    logic [4:0]  s_opc;
    logic [7:0]  s_op1, s_op2;
    logic [2:0]  s_rd;
    logic [2:0]  s_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    scalar_operand_stage dut (
        .clk(clk), .reset(reset), .inValid(inValid),
        .inOpcode(inOpcode), .rSel1(rSel1), .rSel2(rSel2),
        .use1(use1), .use2(use2), .reg1In(reg1In), .reg2In(reg2In),
        .inRd(inRd), .inRegWrEn(inRegWrEn), .inIsLoad(inIsLoad),
        .exResult(exResult), .wbWrEn(wbWrEn), .wbRd(wbRd),
        .wbData(wbData), .exStall(exStall), .flush(flush),
        .outValid(outValid), .outOpcode(outOpcode),
        .outOp1(outOp1), .outOp2(outOp2), .outRd(outRd),
        .outRegWrEn(outRegWrEn), .outIsLoad(outIsLoad),
        .stallOut(stallOut), .bubbleCount(bubbleCount)
    );

    scalar_operand_stage #(.counterSize(3)) dut_sat (
        .clk(clk), .reset(reset), .inValid(inValid),
        .inOpcode(inOpcode), .rSel1(rSel1), .rSel2(rSel2),
        .use1(use1), .use2(use2), .reg1In(reg1In), .reg2In(reg2In),
        .inRd(inRd), .inRegWrEn(inRegWrEn), .inIsLoad(inIsLoad),
        .exResult(exResult), .wbWrEn(wbWrEn), .wbRd(wbRd),
        .wbData(wbData), .exStall(exStall), .flush(flush),
        .outValid(s_valid), .outOpcode(s_opc),
        .outOp1(s_op1), .outOp2(s_op2), .outRd(s_rd),
        .outRegWrEn(s_wr), .outIsLoad(s_ld),
        .stallOut(s_stall), .bubbleCount(s_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inValid = 0; inOpcode = 0; rSel1 = 0; rSel2 = 0;
        use1 = 0; use2 = 0; reg1In = 0; reg2In = 0;
        inRd = 0; inRegWrEn = 0; inIsLoad = 0; exResult = 0;
        wbWrEn = 0; wbRd = 0; wbData = 0; exStall = 0; flush = 0;
    endtask

    // Decode presents a load to r1 (reads nothing).
    task automatic drive_load_r1();
        idle();
        inValid = 1; inOpcode = 5'd1; inRd = 3'd1;
        inRegWrEn = 1; inIsLoad = 1;
    endtask

    // Decode presents a consumer of r1.
    task automatic drive_use_r1(input logic u);
        idle();
        inValid = 1; inOpcode = 5'd7; rSel1 = 3'd1; use1 = u;
        reg1In = 8'h22; inRd = 3'd5; inRegWrEn = 1;
    endtask

    initial begin
        idle();
        reset = 0;
        // Reset with random (non-stall) inputs
        repeat (3) begin
            inValid   = 1'($urandom);
            inOpcode  = 5'($urandom);
            rSel1     = 3'($urandom);
            rSel2     = 3'($urandom);
            use1      = 1'($urandom);
            use2      = 1'($urandom);
            reg1In    = 8'($urandom);
            reg2In    = 8'($urandom);
            inRd      = 3'($urandom);
            inRegWrEn = 1'($urandom);
            inIsLoad  = 1'($urandom);
            exResult  = 8'($urandom);
            wbWrEn    = 1'($urandom);
            wbData    = 8'($urandom);
            flush     = 1'($urandom);
            tick();
        end
        chk("rst_valid", 32'(outValid), 0);
        chk("rst_opc", 32'(outOpcode), 0);
        chk("rst_op1", 32'(outOp1), 0);
        chk("rst_op2", 32'(outOp2), 0);
        chk("rst_wr_ld", {30'd0, outRegWrEn, outIsLoad}, 0);
        chk("rst_cnt", 32'(bubbleCount), 0);
        chk("rst_stall", 32'(stallOut), 0);

        idle();
        reset = 1;
        inValid = 1; inOpcode = 5'd3; reg1In = 8'h11;
        tick();
        chk("cap_valid", 32'(outValid), 1);
        chk("cap_opc", 32'(outOpcode), 3);
        chk("cap_op1", 32'(outOp1), 32'h11);

        // EX forward
        idle();
        inValid = 1; inRd = 3'd2; inRegWrEn = 1; inOpcode = 5'd4;
        tick();
        idle();
        exResult = 8'hA5;
        inValid = 1; rSel1 = 3'd2; use1 = 1; reg1In = 8'h00;
        tick();
        chk("ex_fwd", 32'(outOp1), 32'hA5);

        // WB forward, then EX beats WB on the same source
        idle();
        wbWrEn = 1; wbRd = 3'd4; wbData = 8'h3C;
        inValid = 1; rSel2 = 3'd4; use2 = 1; reg2In = 8'h00;
        inRd = 3'd4; inRegWrEn = 1;
        tick();
        chk("wb_fwd", 32'(outOp2), 32'h3C);
        exResult = 8'h77;
        tick();
        chk("ex_over_wb", 32'(outOp2), 32'h77);

        // Both sources on same register, both forwarded
        rSel1 = 3'd4; use1 = 1; exResult = 8'h66;
        tick();
        chk("both_op1", 32'(outOp1), 32'h66);
        chk("both_op2", 32'(outOp2), 32'h66);

        // Load-use
        drive_load_r1();
        tick();
        drive_use_r1(1);
        #1;
        chk("lu_stall", 32'(stallOut), 1);
        tick();
        chk("lu_bubble", 32'(outValid), 0);
        chk("lu_cnt", 32'(bubbleCount), 1);
        wbWrEn = 1; wbRd = 3'd1; wbData = 8'h5A;
        #1;
        chk("lu_nostall", 32'(stallOut), 0);
        tick();
        chk("lu_valid", 32'(outValid), 1);
        chk("lu_op1", 32'(outOp1), 32'h5A);
        chk("lu_opc", 32'(outOpcode), 7);

        // Unused source never stalls
        drive_load_r1();
        tick();
        drive_use_r1(0);
        #1;
        chk("nouse_stall", 32'(stallOut), 0);
        tick();
        chk("nouse_op1", 32'(outOp1), 32'h22);
        chk("nouse_cnt", 32'(bubbleCount), 1);

        // exStall holds for 3 cycles
        idle();
        inValid = 1; inOpcode = 5'd9; reg1In = 8'h44;
        tick();
        inOpcode = 5'd10; reg1In = 8'h55; exStall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_stall", 32'(stallOut), 1);
            tick();
            chk("hold_opc", 32'(outOpcode), 9);
            chk("hold_op1", 32'(outOp1), 32'h44);
        end

        // exStall with load-use: hold, not counted
        drive_load_r1();
        tick();
        drive_use_r1(1);
        exStall = 1;
        tick();
        chk("stlu_ld", {30'd0, outValid, outIsLoad}, 3);
        chk("stlu_cnt", 32'(bubbleCount), 1);
        // flush wins over exStall and load-use
        flush = 1;
        tick();
        chk("fl_valid", 32'(outValid), 0);
        chk("fl_cnt", 32'(bubbleCount), 1);

        // Hazard re-evaluated after exStall drops
        drive_load_r1();
        tick();
        drive_use_r1(1);
        exStall = 1;
        tick();
        exStall = 0;
        tick();
        chk("restl_bubble", 32'(outValid), 0);
        chk("restl_cnt", 32'(bubbleCount), 2);

        // Reset during load-use stall
        drive_load_r1();
        tick();
        drive_use_r1(1);
        #1;
        chk("mr_pre", 32'(stallOut), 1);
        reset = 0;
        #1;
        chk("mr_stall", 32'(stallOut), 0);
        chk("mr_valid", 32'(outValid), 0);
        chk("mr_cnt", 32'(bubbleCount), 0);
        tick();
        reset = 1;

        // Saturation: 9 bubbles into a 3-bit counter
        idle();
        inValid = 1; inOpcode = 5'd1; rSel1 = 3'd1; use1 = 1;
        inRd = 3'd1; inRegWrEn = 1; inIsLoad = 1;
        repeat (18) tick();
        chk("sat_main", 32'(bubbleCount), 9);
        chk("sat_small", 32'(s_cnt), 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/scalar_operand_stage.md
Name: scalar_operand_stage

Overview:
- Decode-to-execute pipeline register directly downstream of the scalar register file.
- Captures the two scalar read operands reg1Out/reg2Out with the decoded instruction fields.
- Resolves RAW hazards: forwards from execute and writeback, and inserts a one-cycle bubble on load-use.
- Drives the scalar execute stage; holds a saturating bubble counter for performance monitoring.

Parameters:
- registerSize, 8, scalar datapath width; must match the register file.
- selectionBits, 3, register select width; must match the register file.
- opcodeSize, 5, width of the opaque decoded opcode field.
- counterSize, 16, bubble counter width.

Ports:
- clk  in  1  stage clock.
- reset  in  1  asynchronous, active-low reset.
- inValid  in  1  decode holds a valid instruction.
- inOpcode  in  opcodeSize  decoded opcode.
- rSel1, rSel2  in  selectionBits  source selects; same values drive the register file.
- use1, use2  in  1  source operand actually read.
- reg1In, reg2In  in  registerSize  register file reg1Out/reg2Out.
- inRd  in  selectionBits  destination register.
- inRegWrEn  in  1  instruction writes inRd.
- inIsLoad  in  1  result comes from memory; not available in execute.
- exResult  in  registerSize  combinational execute result of the instruction held in this stage.
- wbWrEn  in  1  writeback enable; same net as register file regWrEn.
- wbRd  in  selectionBits  writeback target; same net as regToWrite.
- wbData  in  registerSize  writeback data; same net as dataIn.
- exStall  in  1  execute cannot accept; hold stage.
- flush  in  1  kill the instruction entering the stage.
- outValid, outOpcode, outOp1, outOp2, outRd, outRegWrEn, outIsLoad  out  as input widths  registered instruction presented to execute.
- stallOut  out  1  decode must hold its inputs this cycle.
- bubbleCount  out  counterSize  number of load-use bubbles inserted.

Behaviour:
- Reset (reset=0, asynchronous): all out* registers = 0 and bubbleCount = 0. stallOut is combinational and evaluates to 0 because outValid = 0.
- Operand selection, per source n, combinational, in priority order:
  - EX forward: outValid & outRegWrEn & !outIsLoad & rSeln==outRd → exResult.
  - WB forward: wbWrEn & rSeln==wbRd → wbData. Needed because the register file updates only on the write edge.
  - Otherwise regnIn.
  - Operands with usen=0 take regnIn and are never checked for hazards.
- Load-use hazard:
  - loadUse = inValid & outValid & outIsLoad & outRegWrEn & ((use1 & rSel1==outRd) | (use2 & rSel2==outRd)).
- stallOut = exStall | (loadUse & !flush).
- Next state on rising clk, in priority order:
  1. flush=1: load a bubble (outValid=0, outRegWrEn=0, outIsLoad=0; other fields don't-care, drive 0). flush wins over exStall and loadUse. bubbleCount unchanged.
  2. exStall=1: all out* hold. bubbleCount unchanged.
  3. loadUse=1: load a bubble. bubbleCount += 1, saturating at all-ones with no wrap. Next cycle the load sits in writeback and the operand arrives through WB forwarding.
  4. Otherwise: capture inValid, inOpcode, selected operands, inRd, inRegWrEn, inIsLoad.
- Latency: one cycle from decode to the out* registers.
- Boundary cases:
  - inValid=0 is captured as a bubble. A bubble never forwards and never triggers a stall.
  - When EX and WB both match the same source, EX wins (younger instruction).
  - When both sources match, each forwards independently.
  - rSel1==rSel2 is legal; both sources receive identical data.
  - exStall with loadUse: hold, not counted. The hazard is re-evaluated after exStall drops.
  - Reset asserted mid-stall clears everything immediately; stallOut drops combinationally.

Test Plan:
- Reset: hold reset=0 with random inputs → all out* = 0, bubbleCount = 0, stallOut = 0; release, then inValid=1, inOpcode=3, reg1In=8'h11 → next cycle outValid=1, outOpcode=3, outOp1=8'h11.
- EX forward: instruction A (inRd=2, inRegWrEn=1) in stage with exResult=8'hA5; next instruction rSel1=2, use1=1, reg1In=8'h00 → captured outOp1=8'hA5.
- WB forward and priority: wbWrEn=1, wbRd=4, wbData=8'h3C, rSel2=4 → outOp2=8'h3C. Repeat with EX also targeting 4 and exResult=8'h77 → outOp2=8'h77.
- Load-use: load to r1 in stage (outIsLoad=1), decode rSel1=1, use1=1 → stallOut=1 for one cycle, bubble inserted, bubbleCount=1. Next cycle wbWrEn=1, wbRd=1, wbData=8'h5A → outOp1=8'h5A and stallOut=0. Repeat with use1=0 → no stall.
- Flush and exStall: exStall=1 for 3 cycles → out* stable and stallOut=1. Assert flush together with exStall and loadUse → outValid=0 next cycle, bubbleCount unchanged.
- Saturation: preload the counter via 65535 load-use bubbles (or force it) → a further bubble leaves bubbleCount=16'hFFFF.
